// File: rtl/mapping_job_scheduler_if.sv
// Handshake bundle between the mapping job scheduler and its environment
// (seed/index table, candidate FIFO, SW_top and the job controller).
interface mapping_job_scheduler_if #(
    parameter int READ_W  = 4,
    parameter int CAND_W  = 4,
    parameter int SCORE_W = 8
);
    logic               start;
    logic [READ_W-1:0]  num_reads;
    logic [READ_W-1:0]  tbl_addr;
    logic [CAND_W-1:0]  tbl_cnt;
    logic [READ_W-1:0]  sr_sel;
    logic [CAND_W-1:0]  ref_sel;
    logic               fifo_wr_en;
    logic               fifo_full;
    logic               sw_start;
    logic               sw_done;
    logic [SCORE_W-1:0] sw_score;
    logic               res_valid;
    logic [CAND_W-1:0]  res_cand;
    logic [SCORE_W-1:0] res_score;
    logic               busy;
    logic               done;
    logic               tmo_err;

    modport master (
        input  start, num_reads, tbl_cnt, fifo_full, sw_done, sw_score,
        output tbl_addr, sr_sel, ref_sel, fifo_wr_en, sw_start,
               res_valid, res_cand, res_score, busy, done, tmo_err
    );

    modport slave (
        output start, num_reads, tbl_cnt, fifo_full, sw_done, sw_score,
        input  tbl_addr, sr_sel, ref_sel, fifo_wr_en, sw_start,
               res_valid, res_cand, res_score, busy, done, tmo_err
    );
endinterface

// File: rtl/mapping_job_scheduler.sv
// Short-read mapping sequencer: per read, pushes each candidate window, launches SW, keeps the best score.
// Optional SW watchdog enabled by defining SCHED_TIMEOUT_EN.
module mapping_job_scheduler #(
    parameter int READ_W  = 4,
    parameter int CAND_W  = 4,
    parameter int SCORE_W = 8,
    parameter int TMO_W   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    mapping_job_scheduler_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_PUSH   = 3'd2,
        S_LAUNCH = 3'd3,
        S_WAIT   = 3'd4,
        S_REPORT = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t             state_r;
    logic [READ_W-1:0]  nreads_r;
    logic [CAND_W-1:0]  cnt_r;
    logic [SCORE_W-1:0] best_score_r;
    logic [CAND_W-1:0]  best_cand_r;
    logic [READ_W-1:0]  tbl_addr_r;
    logic [READ_W-1:0]  sr_sel_r;
    logic [CAND_W-1:0]  ref_sel_r;
    logic               fifo_wr_en_r;
    logic               sw_start_r;
    logic               res_valid_r;
    logic [CAND_W-1:0]  res_cand_r;
    logic [SCORE_W-1:0] res_score_r;
    logic               busy_r;
    logic               done_r;

    logic               cand_end_s;
    logic [SCORE_W-1:0] eff_score_s;
    logic [SCORE_W-1:0] new_score_s;
    logic [CAND_W-1:0]  new_cand_s;
    logic               last_cand_s;
    logic               last_read_s;

`ifdef SCHED_TIMEOUT_EN
    logic [TMO_W-1:0]   tmo_cnt_r;
    logic               tmo_err_r;
    logic               tmo_hit_s;
`endif

    // Candidate completion, best-so-far update and end-of-list detection
    always_comb begin
`ifdef SCHED_TIMEOUT_EN
        tmo_hit_s   = (tmo_cnt_r == {TMO_W{1'b1}}) && !bus.sw_done;
        cand_end_s  = bus.sw_done || tmo_hit_s;
        eff_score_s = bus.sw_done ? bus.sw_score : {SCORE_W{1'b0}};
`else
        cand_end_s  = bus.sw_done;
        eff_score_s = bus.sw_score;
`endif
        // Strict compare: on a tie the earlier candidate stays best
        if (eff_score_s > best_score_r) begin
            new_score_s = eff_score_s;
            new_cand_s  = ref_sel_r;
        end else begin
            new_score_s = best_score_r;
            new_cand_s  = best_cand_r;
        end
        last_cand_s = (ref_sel_r == (cnt_r - CAND_W'(1)));
        last_read_s = (sr_sel_r == (nreads_r - READ_W'(1)));
    end

    // Job sequencing FSM with registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= S_IDLE;
            nreads_r     <= {READ_W{1'b0}};
            cnt_r        <= {CAND_W{1'b0}};
            best_score_r <= {SCORE_W{1'b0}};
            best_cand_r  <= {CAND_W{1'b0}};
            tbl_addr_r   <= {READ_W{1'b0}};
            sr_sel_r     <= {READ_W{1'b0}};
            ref_sel_r    <= {CAND_W{1'b0}};
            fifo_wr_en_r <= 1'b0;
            sw_start_r   <= 1'b0;
            res_valid_r  <= 1'b0;
            res_cand_r   <= {CAND_W{1'b0}};
            res_score_r  <= {SCORE_W{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
            tmo_cnt_r    <= {TMO_W{1'b0}};
            tmo_err_r    <= 1'b0;
`endif
        end else begin
            fifo_wr_en_r <= 1'b0;
            sw_start_r   <= 1'b0;
            res_valid_r  <= 1'b0;
            done_r       <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (bus.start && (bus.num_reads != {READ_W{1'b0}})) begin
                        nreads_r   <= bus.num_reads;
                        sr_sel_r   <= {READ_W{1'b0}};
                        tbl_addr_r <= {READ_W{1'b0}};
                        busy_r     <= 1'b1;
                        state_r    <= S_FETCH;
                    end else if (bus.start) begin
                        done_r  <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_FETCH: begin
                    cnt_r        <= bus.tbl_cnt;
                    ref_sel_r    <= {CAND_W{1'b0}};
                    best_score_r <= {SCORE_W{1'b0}};
                    best_cand_r  <= {CAND_W{1'b0}};
                    if (bus.tbl_cnt == {CAND_W{1'b0}}) begin
                        res_valid_r <= 1'b1;
                        res_cand_r  <= {CAND_W{1'b0}};
                        res_score_r <= {SCORE_W{1'b0}};
                        state_r     <= S_REPORT;
                    end else begin
                        state_r <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    if (!bus.fifo_full) begin
                        fifo_wr_en_r <= 1'b1;
                        state_r      <= S_LAUNCH;
                    end else begin
                        state_r <= S_PUSH;
                    end
                end
                S_LAUNCH: begin
                    sw_start_r <= 1'b1;
`ifdef SCHED_TIMEOUT_EN
                    tmo_cnt_r  <= {TMO_W{1'b0}};
`endif
                    state_r    <= S_WAIT;
                end
                S_WAIT: begin
`ifdef SCHED_TIMEOUT_EN
                    if (tmo_hit_s) begin
                        tmo_err_r <= 1'b1;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                    end
`endif
                    if (cand_end_s) begin
                        best_score_r <= new_score_s;
                        best_cand_r  <= new_cand_s;
                        if (last_cand_s) begin
                            res_valid_r <= 1'b1;
                            res_cand_r  <= new_cand_s;
                            res_score_r <= new_score_s;
                            state_r     <= S_REPORT;
                        end else begin
                            ref_sel_r <= ref_sel_r + CAND_W'(1);
                            state_r   <= S_PUSH;
                        end
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                S_REPORT: begin
                    if (last_read_s) begin
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= S_DONE;
                    end else begin
                        sr_sel_r   <= sr_sel_r + READ_W'(1);
                        tbl_addr_r <= tbl_addr_r + READ_W'(1);
                        state_r    <= S_FETCH;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.tbl_addr   = tbl_addr_r;
    assign bus.sr_sel     = sr_sel_r;
    assign bus.ref_sel    = ref_sel_r;
    assign bus.fifo_wr_en = fifo_wr_en_r;
    assign bus.sw_start   = sw_start_r;
    assign bus.res_valid  = res_valid_r;
    assign bus.res_cand   = res_cand_r;
    assign bus.res_score  = res_score_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
`ifdef SCHED_TIMEOUT_EN
    assign bus.tmo_err    = tmo_err_r;
`else
    assign bus.tmo_err    = 1'b0;
`endif
endmodule
